// File: rtl/uart_rx_ctrl_if.sv
// Signal bundle between the UART receive controller and the rest of the receive path.
// The slave side is the controller; the master side feeds the line and checker results.
interface uart_rx_ctrl_if;
    logic       RX_IN;
    logic       PAR_EN;
    logic [5:0] Prescale;
    logic       strt_glitch;
    logic       par_err;
    logic       stp_err;
    logic [4:0] edge_cnt;
    logic [3:0] bit_cnt;
    logic       dat_samp_en;
    logic       strt_chk_en;
    logic       deser_en;
    logic       par_chk_en;
    logic       stp_chk_en;
    logic       data_valid;
    logic       frame_err;
    logic       par_err_flg;

    modport master (
        output RX_IN, PAR_EN, Prescale, strt_glitch, par_err, stp_err,
        input  edge_cnt, bit_cnt, dat_samp_en, strt_chk_en, deser_en,
               par_chk_en, stp_chk_en, data_valid, frame_err, par_err_flg
    );

    modport slave (
        input  RX_IN, PAR_EN, Prescale, strt_glitch, par_err, stp_err,
        output edge_cnt, bit_cnt, dat_samp_en, strt_chk_en, deser_en,
               par_chk_en, stp_chk_en, data_valid, frame_err, par_err_flg
    );
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: start detect, edge/bit counting, checker enables and
// end-of-frame qualification into data_valid / frame_err / par_err_flg pulses.
module uart_rx_ctrl (
    input  logic          clk,
    input  logic          ARST_n,
    uart_rx_ctrl_if.slave bus
);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    logic [2:0] state;
    logic [4:0] edge_q;
    logic [3:0] bit_q;
    logic [4:0] edge_max;
    logic [4:0] edge_max_sel;
    logic       par_en_q;
    logic       sticky;
    logic       dv_q, fe_q, pe_q;
    logic       bit_end;

    // Stored as P-1 so the bit-end compare needs no subtractor; illegal ratios fall back to 8.
    always_comb begin
        edge_max_sel = 5'd7;
        case (bus.Prescale)
            6'd16:   edge_max_sel = 5'd15;
            6'd32:   edge_max_sel = 5'd31;
            default: edge_max_sel = 5'd7;
        endcase
    end

    assign bit_end = (edge_q == edge_max);

    always_ff @(posedge clk or negedge ARST_n) begin
        if (!ARST_n) begin
            state    <= IDLE;
            edge_q   <= 5'd0;
            bit_q    <= 4'd0;
            edge_max <= 5'd7;
            par_en_q <= 1'b0;
            sticky   <= 1'b0;
            dv_q     <= 1'b0;
            fe_q     <= 1'b0;
            pe_q     <= 1'b0;
        end else begin
            dv_q <= 1'b0;
            fe_q <= 1'b0;
            pe_q <= 1'b0;
            if (state == IDLE) begin
                edge_q <= 5'd0;
                bit_q  <= 4'd0;
                sticky <= 1'b0;
                // The detect cycle is edge 0, so counting resumes at 1.
                if (!bus.RX_IN) begin
                    state    <= START;
                    edge_q   <= 5'd1;
                    edge_max <= edge_max_sel;
                    par_en_q <= bus.PAR_EN;
                end
            end else begin
                edge_q <= bit_end ? 5'd0 : edge_q + 5'd1;
                if (bit_end) begin
                    bit_q <= bit_q + 4'd1;
                    case (state)
                        START: begin
                            if (bus.strt_glitch) begin
                                state <= IDLE;
                                bit_q <= 4'd0;
                            end else begin
                                state <= DATA;
                            end
                        end
                        DATA: begin
                            if (bit_q == 4'd8)
                                state <= par_en_q ? PARITY : STOP;
                        end
                        PARITY: begin
                            sticky <= bus.par_err;
                            state  <= STOP;
                        end
                        STOP: begin
                            state <= IDLE;
                            bit_q <= 4'd0;
                            dv_q  <= !bus.stp_err && !sticky;
                            fe_q  <= bus.stp_err;
                            pe_q  <= sticky;
                        end
                        default: begin
                            state <= IDLE;
                            bit_q <= 4'd0;
                        end
                    endcase
                end
            end
        end
    end

    assign bus.edge_cnt    = edge_q;
    assign bus.bit_cnt     = bit_q;
    assign bus.dat_samp_en = (state == START) || (state == DATA) ||
                             (state == PARITY) || (state == STOP);
    assign bus.strt_chk_en = (state == START);
    assign bus.deser_en    = (state == DATA);
    assign bus.par_chk_en  = (state == PARITY);
    assign bus.stp_chk_en  = (state == STOP);
    assign bus.data_valid  = dv_q;
    assign bus.frame_err   = fe_q;
    assign bus.par_err_flg = pe_q;
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Randomized bench for uart_rx_ctrl: frames are described at the protocol level,
// expected end-of-frame outcomes queue up and a monitor checks them as frames close.
module tb_uart_rx_ctrl;
    logic clk = 1'b0;
    logic ARST_n = 1'b0;
    always #5 clk = ~clk;

    uart_rx_ctrl_if bus();
    uart_rx_ctrl u_dut (.clk(clk), .ARST_n(ARST_n), .bus(bus));

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int end_cyc;
        int dv, fe, pf;
        int deser, par, stp, strt;
        int maxbit, maxedge;
    } exp_t;

    exp_t sb[$];
    int tests = 0;
    int fails = 0;
    int pushed = 0;
    int seen = 0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int eff_p(input int pr);
        return (pr == 16 || pr == 32) ? pr : 8;
    endfunction

    // Monitor: a frame closes when the receiver drops back to idle.
    initial begin : monitor
        bit prev;
        int c_deser, c_par, c_stp, c_strt, mbit, medge;
        exp_t e;
        prev = 0;
        c_deser = 0; c_par = 0; c_stp = 0; c_strt = 0; mbit = 0; medge = 0;
        forever begin
            @(negedge clk);
            if (!ARST_n) begin
                prev = 0;
                c_deser = 0; c_par = 0; c_stp = 0; c_strt = 0; mbit = 0; medge = 0;
                continue;
            end
            if (bus.dat_samp_en) begin
                c_deser += int'(bus.deser_en);
                c_par   += int'(bus.par_chk_en);
                c_stp   += int'(bus.stp_chk_en);
                c_strt  += int'(bus.strt_chk_en);
                if (int'(bus.bit_cnt) > mbit) mbit = int'(bus.bit_cnt);
                if (int'(bus.edge_cnt) > medge) medge = int'(bus.edge_cnt);
                check("pulse_outside_idle",
                      int'({bus.data_valid, bus.frame_err, bus.par_err_flg}), 0);
            end else if (prev) begin
                check("frame_expected", int'(sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    seen++;
                    check("end_cycle",   int'(cyc), e.end_cyc);
                    check("data_valid",  int'(bus.data_valid), e.dv);
                    check("frame_err",   int'(bus.frame_err), e.fe);
                    check("par_err_flg", int'(bus.par_err_flg), e.pf);
                    check("deser_cycles", c_deser, e.deser);
                    check("par_cycles",  c_par, e.par);
                    check("stp_cycles",  c_stp, e.stp);
                    check("strt_cycles", c_strt, e.strt);
                    check("max_bit_cnt", mbit, e.maxbit);
                    check("max_edge_cnt", medge, e.maxedge);
                    check("idle_counters", int'({bus.edge_cnt, bus.bit_cnt}), 0);
                end
                c_deser = 0; c_par = 0; c_stp = 0; c_strt = 0; mbit = 0; medge = 0;
            end else begin
                check("stray_pulse",
                      int'({bus.data_valid, bus.frame_err, bus.par_err_flg}), 0);
            end
            prev = bus.dat_samp_en;
        end
    end

    task automatic nc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle();
        bus.RX_IN       = 1'b1;
        bus.strt_glitch = 1'($urandom);
        bus.par_err     = 1'($urandom);
        bus.stp_err     = 1'($urandom);
        nc();
    endtask

    // One frame starting with its detect cycle; checker results are only
    // meaningful inside their own bit and random elsewhere.
    task automatic frame(input int presc, input int mid_presc, input bit par_en,
                         input bit glitch, input bit perr, input bit serr);
        int   p, len, pe;
        exp_t e;
        p   = eff_p(presc);
        pe  = glitch ? 0 : int'(par_en);
        len = glitch ? p : (10 + pe) * p;
        e.end_cyc = int'(cyc) + len;
        e.dv      = (!glitch && !serr && !(pe == 1 && perr)) ? 1 : 0;
        e.fe      = (!glitch && serr) ? 1 : 0;
        e.pf      = (!glitch && pe == 1 && perr) ? 1 : 0;
        e.deser   = glitch ? 0 : 8 * p;
        e.par     = pe * p;
        e.stp     = glitch ? 0 : p;
        e.strt    = p - 1;
        e.maxbit  = glitch ? 0 : 9 + pe;
        e.maxedge = p - 1;
        sb.push_back(e);
        pushed++;
        for (int k = 0; k < len; k++) begin
            bus.RX_IN = (k == 0) ? 1'b0 : 1'($urandom);
            if (k == 0) begin
                bus.Prescale = 6'(presc);
                bus.PAR_EN   = par_en;
            end
            if (k == 3) begin
                bus.Prescale = 6'(mid_presc);
                bus.PAR_EN   = 1'($urandom);
            end
            bus.strt_glitch = (k < p) ? glitch : 1'($urandom);
            bus.par_err     = (pe == 1 && k >= 9 * p && k < 10 * p) ? perr : 1'($urandom);
            bus.stp_err     = (!glitch && k >= (9 + pe) * p) ? serr : 1'($urandom);
            nc();
        end
        bus.RX_IN = 1'b1;
    endtask

    function automatic int rand_presc();
        case ($urandom_range(0, 5))
            0, 1:    return 8;
            2:       return 16;
            3:       return 32;
            4:       return 12;
            default: return int'($urandom_range(0, 63));
        endcase
    endfunction

    initial begin : stim
        int bad;
        bus.RX_IN = 1'b1;
        bus.PAR_EN = 1'b0;
        bus.Prescale = 6'd8;
        bus.strt_glitch = 1'b0;
        bus.par_err = 1'b0;
        bus.stp_err = 1'b0;

        #12;
        check("rst_edge_cnt", int'(bus.edge_cnt), 0);
        check("rst_bit_cnt", int'(bus.bit_cnt), 0);
        check("rst_enables", int'({bus.dat_samp_en, bus.strt_chk_en, bus.deser_en,
                                   bus.par_chk_en, bus.stp_chk_en}), 0);
        check("rst_pulses", int'({bus.data_valid, bus.frame_err, bus.par_err_flg}), 0);
        nc();
        ARST_n = 1'b1;
        repeat (3) idle_cycle();

        // Asynchronous reset in the middle of a start bit.
        bus.RX_IN = 1'b0;
        bus.Prescale = 6'd8;
        nc();
        bus.RX_IN = 1'b1;
        nc();
        nc();
        check("pre_rst_edge_cnt", int'(bus.edge_cnt), 3);
        #1 ARST_n = 1'b0;
        #1;
        check("arst_edge_cnt", int'(bus.edge_cnt), 0);
        check("arst_enables", int'({bus.dat_samp_en, bus.strt_chk_en, bus.deser_en,
                                    bus.par_chk_en, bus.stp_chk_en}), 0);
        check("arst_pulses", int'({bus.data_valid, bus.frame_err, bus.par_err_flg}), 0);
        nc();
        nc();
        ARST_n = 1'b1;
        bad = 0;
        repeat (100) begin
            idle_cycle();
            if (bus.dat_samp_en || bus.edge_cnt != 5'd0 || bus.bit_cnt != 4'd0) bad++;
        end
        check("idle_100_cycles", bad, 0);

        // Directed frames
        frame(8, 8, 1'b0, 1'b0, 1'b0, 1'b0);     // clean, P=8
        repeat (2) idle_cycle();
        frame(16, 16, 1'b1, 1'b0, 1'b1, 1'b0);   // parity error, P=16
        repeat (2) idle_cycle();
        frame(8, 8, 1'b0, 1'b1, 1'b0, 1'b0);     // start glitch
        repeat (2) idle_cycle();
        frame(32, 32, 1'b0, 1'b0, 1'b0, 1'b1);   // stop error, P=32
        repeat (2) idle_cycle();
        frame(8, 16, 1'b0, 1'b0, 1'b0, 1'b0);    // back-to-back, prescale switched mid-frame
        frame(16, 16, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) idle_cycle();
        frame(12, 12, 1'b1, 1'b0, 1'b0, 1'b0);   // illegal ratio runs at 8
        frame(16, 8, 1'b1, 1'b0, 1'b1, 1'b1);    // both error pulses together

        // Randomized frames with random gaps, including zero gap
        for (int n = 0; n < 24; n++) begin
            frame(rand_presc(), int'($urandom_range(0, 63)), 1'($urandom),
                  ($urandom_range(0, 5) == 0), 1'($urandom), ($urandom_range(0, 2) == 0));
            repeat ($urandom_range(0, 3)) idle_cycle();
        end

        repeat (20) idle_cycle();
        check("sb_drain", sb.size(), 0);
        check("frames_seen", seen, pushed);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
